// File: rtl/alu_pkg.sv
// alu_pkg: function codes and flag bit positions shared by the ALU pipeline
package alu_pkg;
   localparam logic [3:0] FN_ADD  = 4'd0;
   localparam logic [3:0] FN_SUB  = 4'd1;
   localparam logic [3:0] FN_MUL  = 4'd2;
   localparam logic [3:0] FN_A    = 4'd3;
   localparam logic [3:0] FN_B    = 4'd4;
   localparam logic [3:0] FN_AND  = 4'd5;
   localparam logic [3:0] FN_OR   = 4'd6;
   localparam logic [3:0] FN_XOR  = 4'd7;
   localparam logic [3:0] FN_NEGA = 4'd8;
   localparam logic [3:0] FN_NEGB = 4'd9;
   localparam logic [3:0] FN_SHR  = 4'd10;
   localparam logic [3:0] FN_SHL  = 4'd11;
   localparam logic [3:0] FN_ROTL = 4'd12;
   localparam logic [3:0] FN_ROTR = 4'd13;
   localparam logic [3:0] FN_SLT  = 4'd14;
   localparam logic [3:0] FN_NOP  = 4'd15;
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;
endpackage

// File: rtl/alu_exec.sv
// alu_exec: combinational ALU core producing result, carry/borrow and signed overflow
module alu_exec
   import alu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        func,
   output logic [DATA_W-1:0] z,
   output logic              carry,
   output logic              ovf
);
   localparam int M = DATA_W - 1;
   logic [DATA_W:0]   sum, dif;
   logic [DATA_W-1:0] prod, na, nb;
   assign sum  = {1'b0, a} + {1'b0, b};
   assign dif  = {1'b0, a} - {1'b0, b};
   assign prod = a * b;
   assign na   = '0 - a;
   assign nb   = '0 - b;
   // Negation only overflows on the most negative value, which maps onto itself
   always_comb begin
      z     = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (func)
         FN_ADD:  begin z = sum[M:0]; carry = sum[DATA_W]; ovf = (a[M] == b[M]) && (sum[M] != a[M]); end
         FN_SUB:  begin z = dif[M:0]; carry = dif[DATA_W]; ovf = (a[M] != b[M]) && (dif[M] != a[M]); end
         FN_MUL:  z = prod;
         FN_A:    z = a;
         FN_B:    z = b;
         FN_AND:  z = a & b;
         FN_OR:   z = a | b;
         FN_XOR:  z = a ^ b;
         FN_NEGA: begin z = na; ovf = a[M] && na[M]; end
         FN_NEGB: begin z = nb; ovf = b[M] && nb[M]; end
         FN_SHR:  begin z = {1'b0, a[M:1]}; carry = a[0]; end
         FN_SHL:  begin z = {a[M-1:0], 1'b0}; carry = a[M]; end
         FN_ROTL: z = {a[M-1:0], a[M]};
         FN_ROTR: z = {a[0], a[M:1]};
         FN_SLT:  z = {{M{1'b0}}, $signed(a) < $signed(b)};
         default: z = '0;
      endcase
   end
endmodule

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: 4-stage ALU pipeline (read, execute, writeback, store) with forwarding and stall
module alu_pipe_param
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int MEM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              in_valid,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic [3:0]        func,
   input  logic [MEM_AW-1:0] addr,
   output logic [DATA_W-1:0] zout,
   output logic              zout_valid,
   output logic [2:0]        flags,
   input  logic [MEM_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   logic [DATA_W-1:0] rf  [2**REG_AW];
   logic [DATA_W-1:0] mem [2**MEM_AW];
   logic              v1, v2, v3;
   logic [DATA_W-1:0] s1_a, s1_b, s2_z, s3_z;
   logic [REG_AW-1:0] s1_rs1, s1_rs2, s1_rd, s2_rd, s3_rd;
   logic [3:0]        s1_func;
   logic [MEM_AW-1:0] s1_addr, s2_addr, s3_addr;
   logic [2:0]        s2_flags, ex_flags;
   logic [DATA_W-1:0] op_a, op_b, ex_z;
   logic              ex_carry, ex_ovf;
   // Younger result (S2) takes precedence over the older one (S3), then the issue-time read
   assign op_a = (v2 && s2_rd == s1_rs1) ? s2_z : (v3 && s3_rd == s1_rs1) ? s3_z : s1_a;
   assign op_b = (v2 && s2_rd == s1_rs2) ? s2_z : (v3 && s3_rd == s1_rs2) ? s3_z : s1_b;
   alu_exec #(.DATA_W(DATA_W)) u_exec (
      .a    (op_a),
      .b    (op_b),
      .func (s1_func),
      .z    (ex_z),
      .carry(ex_carry),
      .ovf  (ex_ovf)
   );
   // Pack execute-stage status into the output flag layout
   always_comb begin
      ex_flags             = '0;
      ex_flags[FLAG_ZERO]  = ex_z == '0;
      ex_flags[FLAG_CARRY] = ex_carry;
      ex_flags[FLAG_OVF]   = ex_ovf;
   end
   // Pipeline latches; a NOP is dropped to an invalid bubble on entering S2 so it writes and forwards nothing
   always_ff @(posedge clk) begin
      if (rst) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         v3         <= 1'b0;
         zout       <= '0;
         flags      <= '0;
         zout_valid <= 1'b0;
      end else if (!stall) begin
         v1         <= in_valid;
         s1_a       <= rf[rs1];
         s1_b       <= rf[rs2];
         s1_rs1     <= rs1;
         s1_rs2     <= rs2;
         s1_rd      <= rd;
         s1_func    <= func;
         s1_addr    <= addr;
         v2         <= v1 && s1_func != FN_NOP;
         s2_z       <= ex_z;
         s2_flags   <= ex_flags;
         s2_rd      <= s1_rd;
         s2_addr    <= s1_addr;
         v3         <= v2;
         s3_z       <= s2_z;
         s3_rd      <= s2_rd;
         s3_addr    <= s2_addr;
         zout_valid <= v2;
         if (v2) begin
            zout  <= s2_z;
            flags <= s2_flags;
         end
      end
   end
   // Register bank: cleared by reset, written back from S2
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
      end else if (!stall && v2) begin
         rf[s2_rd] <= s2_z;
      end
   end
   // Data memory keeps its contents over reset; reset only blocks the store
   always_ff @(posedge clk) begin
      if (!rst && !stall && v3) mem[s3_addr] <= s3_z;
   end
   assign dbg_data = mem[dbg_addr];
endmodule
